// File: rtl/pcie_tx_arbiter_if.sv
// Bundle of the TLP source handshakes, credit advertisements and the core's VC0 transmit port.
// master = the arbiter's view, slave = the sources/core side.
interface pcie_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    src_req;
    logic [N_REQ-1:0]    src_cpl;
    logic [N_REQ*10-1:0] src_len;
    logic [N_REQ-1:0]    src_gnt;
    logic [N_REQ-1:0]    src_st;
    logic [N_REQ-1:0]    src_end;
    logic [N_REQ*16-1:0] src_data;
    logic [8:0]          tx_ca_ph;
    logic [12:0]         tx_ca_pd;
    logic [8:0]          tx_ca_cplh;
    logic [12:0]         tx_ca_cpld;
    logic                tx_ca_p_recheck;
    logic                tx_ca_cpl_recheck;
    logic                tx_req;
    logic                tx_rdy;
    logic                tx_st;
    logic                tx_end;
    logic [15:0]         tx_data;

    modport master (
        input  src_req, src_cpl, src_len, src_st, src_end, src_data,
        input  tx_ca_ph, tx_ca_pd, tx_ca_cplh, tx_ca_cpld,
        input  tx_ca_p_recheck, tx_ca_cpl_recheck, tx_rdy,
        output src_gnt, tx_req, tx_st, tx_end, tx_data
    );

    modport slave (
        output src_req, src_cpl, src_len, src_st, src_end, src_data,
        output tx_ca_ph, tx_ca_pd, tx_ca_cplh, tx_ca_cpld,
        output tx_ca_p_recheck, tx_ca_cpl_recheck, tx_rdy,
        input  src_gnt, tx_req, tx_st, tx_end, tx_data
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Round-robin, credit-aware arbiter sharing the PCIe VC0 transmit port between N_REQ TLP sources.
// The granted source's stream is muxed combinationally onto the core while in XFER.
module pcie_tx_arbiter #(
    parameter int N_REQ  = 2,
    parameter int TO_CYC = 64
) (
    input  logic              clk_125,
    input  logic              sys_rst,
    pcie_tx_arbiter_if.master bus,
    output logic              busy,
    output logic              err_timeout
);
    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t           state;
    state_t           state_nx;
    logic [SW-1:0]    sel;
    logic [SW-1:0]    rr_ptr;
    logic [SW-1:0]    pick;
    logic [SW-1:0]    idx_s;
    logic [CW-1:0]    cnt;
    logic             st_seen;
    logic             any_elig;
    logic             sel_recheck;
    logic             timeout_hit;
    logic [N_REQ-1:0] fit;
    logic [N_REQ-1:0] elig;
    int               idx;

    function automatic logic credit_fit(input logic [8:0] hdr, input logic [12:0] dat,
                                        input logic [9:0] len);
        logic [12:0] need;
        need = (13'(len) + 13'd3) >> 2;
        return (hdr[8] | (hdr[7:0] != 8'd0)) &
               ((len == 10'd0) | dat[12] | ({1'b0, dat[11:0]} >= need));
    endfunction

    always_comb begin
        fit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.src_cpl[i])
                fit[i] = credit_fit(bus.tx_ca_cplh, bus.tx_ca_cpld, bus.src_len[i*10 +: 10]);
            else
                fit[i] = credit_fit(bus.tx_ca_ph, bus.tx_ca_pd, bus.src_len[i*10 +: 10]);
        end
    end

    assign elig = bus.src_req & fit;

    // Scan rr_ptr+1 .. rr_ptr; the first eligible source wins, ineligible ones are skipped.
    always_comb begin
        any_elig = 1'b0;
        pick     = '0;
        idx      = 0;
        idx_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            idx_s = SW'(idx);
            if (!any_elig && elig[idx_s]) begin
                any_elig = 1'b1;
                pick     = idx_s;
            end
        end
    end

    assign sel_recheck = bus.src_cpl[sel] ? bus.tx_ca_cpl_recheck : bus.tx_ca_p_recheck;
    assign timeout_hit = !st_seen && !bus.src_st[sel] && (cnt == CW'(TO_CYC - 1));

    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // tx_rdy is checked first in REQ: once the core commits, credit rechecks no longer matter.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (any_elig) state_nx = REQ;
            REQ: begin
                if (bus.tx_rdy)
                    state_nx = XFER;
                else if ((sel_recheck && !fit[sel]) || !bus.src_req[sel])
                    state_nx = IDLE;
            end
            XFER: if (bus.src_end[sel] || timeout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_req  = 1'b0;
        bus.src_gnt = '0;
        bus.tx_st   = 1'b0;
        bus.tx_end  = 1'b0;
        bus.tx_data = '0;
        busy        = (state != IDLE);
        case (state)
            REQ: bus.tx_req = 1'b1;
            XFER: begin
                bus.src_gnt[sel] = 1'b1;
                bus.tx_st        = bus.src_st[sel];
                bus.tx_end       = bus.src_end[sel];
                bus.tx_data      = bus.src_data[sel*16 +: 16];
            end
            default: ;
        endcase
    end

    // Both a normal end and a timeout abort move the pointer, so the other source goes next.
    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            sel         <= '0;
            rr_ptr      <= SW'(N_REQ - 1);
            cnt         <= '0;
            st_seen     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: if (any_elig) sel <= pick;
                REQ: begin
                    if (bus.tx_rdy) begin
                        cnt     <= '0;
                        st_seen <= 1'b0;
                    end
                end
                XFER: begin
                    if (bus.src_end[sel]) begin
                        rr_ptr <= sel;
                    end else if (timeout_hit) begin
                        rr_ptr      <= sel;
                        err_timeout <= 1'b1;
                    end else if (!st_seen && !bus.src_st[sel]) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (bus.src_st[sel])
                        st_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
